// File: rtl/trans_pkg.sv
// Shared types and field layout for the transaction ingress path.
package trans_pkg;

  localparam int TRANS_W         = 128;
  localparam int WORD_W          = 32;
  localparam int WORDS_PER_TRANS = TRANS_W / WORD_W;
  localparam int SHREG_W         = TRANS_W - WORD_W;
  localparam int BIT_BLOCK_START = 9;

  localparam int SENDER_MSB   = 127;
  localparam int SENDER_LSB   = 80;
  localparam int RECEIVER_MSB = 79;
  localparam int RECEIVER_LSB = 32;
  localparam int AMOUNT_MSB   = 31;
  localparam int AMOUNT_LSB   = 10;
  localparam int RSVD_MSB     = 8;
  localparam int RSVD_LSB     = 0;

  typedef struct packed {
    logic [SENDER_MSB-SENDER_LSB:0]     sender;
    logic [RECEIVER_MSB-RECEIVER_LSB:0] receiver;
    logic [AMOUNT_MSB-AMOUNT_LSB:0]     amount;
    logic                               bs;
    logic [RSVD_MSB-RSVD_LSB:0]         rsvd;
  } trans_t;

endpackage

// File: rtl/trans_fifo.sv
// Synchronous FWFT FIFO. The head entry lives in a dedicated output register;
// entries behind it sit in a register array. level_o counts head + array.
module trans_fifo #(
  parameter int W     = 128,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic [W-1:0]  dout_o,
  output logic          valid_o,
  output logic [CW-1:0] level_o,
  output logic          full_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  head_q, head_d;
  logic          head_vld_q, head_vld_d;
  logic          push, pop, mem_empty, head_free, mem_wr;

  assign full_o  = (count_q == CW'(DEPTH));
  assign push    = push_i & ~full_o;
  assign pop     = pop_i & head_vld_q;
  assign dout_o  = head_q;
  assign valid_o = head_vld_q;
  assign level_o = count_q;

  // Head refill: from the array when it holds data, else bypass the incoming entry
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    head_d     = head_q;
    head_vld_d = head_vld_q;
    mem_wr     = 1'b0;
    mem_empty  = ((count_q - CW'(head_vld_q)) == '0);
    head_free  = ~head_vld_q | pop;
    count_d    = count_q + CW'(push) - CW'(pop);
    if (head_free) begin
      if (!mem_empty) begin
        head_d     = mem_q[rd_ptr_q];
        head_vld_d = 1'b1;
        rd_ptr_d   = rd_ptr_q + 1'b1;
      end else if (push) begin
        head_d     = din_i;
        head_vld_d = 1'b1;
      end else begin
        head_vld_d = 1'b0;
      end
    end
    if (push && !(head_free && mem_empty)) begin
      mem_wr   = 1'b1;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
  end

  // Pointer, count and head registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      head_q     <= '0;
      head_vld_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      head_q     <= head_d;
      head_vld_q <= head_vld_d;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (mem_wr) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/trans_ingress_deser.sv
// Packs 32-bit words into 128-bit transactions, forces the block-start bit
// where requested, and queues transactions toward the validator.
module trans_ingress_deser
  import trans_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  localparam int LW        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WORD_W-1:0]  word_i,
  input  logic               word_valid_i,
  input  logic               word_last_i,
  output logic               word_ready_o,
  input  logic               block_start_i,
  output logic [TRANS_W-1:0] data_o,
  output logic               valid_o,
  input  logic               ack_i,
  output logic [LW-1:0]      level_o,
  output logic               frame_err_o
);

  logic [1:0]         word_idx_q, word_idx_d;
  logic [SHREG_W-1:0] shreg_q, shreg_d;
  logic               force_bs_q, force_bs_d;
  logic               frame_err_q, frame_err_d;
  logic               fifo_full, accept, push;
  trans_t             push_data;

  // Ready depends only on FIFO state; held low while in reset
  assign word_ready_o = rst_n & ~fifo_full;
  assign accept       = word_valid_i & word_ready_o;
  assign frame_err_o  = frame_err_q;

  // Assembler: slot fill, framing checks, block-start forcing
  always_comb begin
    word_idx_d   = word_idx_q;
    shreg_d      = shreg_q;
    force_bs_d   = force_bs_q | block_start_i;
    frame_err_d  = 1'b0;
    push         = 1'b0;
    push_data    = trans_t'({shreg_q, word_i});
    push_data.bs = push_data.bs | force_bs_q;
    if (accept) begin
      if (word_idx_q == 2'd3) begin
        word_idx_d = 2'd0;
        if (word_last_i) begin
          push       = 1'b1;
          // A strobe coinciding with this push applies to the next transaction
          force_bs_d = block_start_i;
        end else begin
          frame_err_d = 1'b1;
        end
      end else if (word_last_i) begin
        word_idx_d  = 2'd0;
        frame_err_d = 1'b1;
      end else begin
        case (word_idx_q)
          2'd0:    shreg_d[95:64] = word_i;
          2'd1:    shreg_d[63:32] = word_i;
          default: shreg_d[31:0]  = word_i;
        endcase
        word_idx_d = word_idx_q + 2'd1;
      end
    end
  end

  // Assembler state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_idx_q  <= 2'd0;
      shreg_q     <= '0;
      force_bs_q  <= 1'b1;
      frame_err_q <= 1'b0;
    end else begin
      word_idx_q  <= word_idx_d;
      shreg_q     <= shreg_d;
      force_bs_q  <= force_bs_d;
      frame_err_q <= frame_err_d;
    end
  end

  trans_fifo #(
    .W     (TRANS_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .din_i   (push_data),
    .pop_i   (ack_i),
    .dout_o  (data_o),
    .valid_o (valid_o),
    .level_o (level_o),
    .full_o  (fifo_full)
  );

endmodule

// File: tb/tb_trans_ingress_deser.sv
// Randomised and directed bench with a queue-based transaction model.
module tb_trans_ingress_deser;
  import trans_pkg::*;

  localparam int D  = 16;
  localparam int LW = $clog2(D) + 1;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic [WORD_W-1:0]  word_i = '0;
  logic               word_valid_i = 1'b0;
  logic               word_last_i = 1'b0;
  logic               word_ready_o;
  logic               block_start_i = 1'b0;
  logic [TRANS_W-1:0] data_o;
  logic               valid_o;
  logic               ack_i = 1'b0;
  logic [LW-1:0]      level_o;
  logic               frame_err_o;

  trans_ingress_deser #(.FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .word_i(word_i), .word_valid_i(word_valid_i),
    .word_last_i(word_last_i), .word_ready_o(word_ready_o),
    .block_start_i(block_start_i), .data_o(data_o), .valid_o(valid_o),
    .ack_i(ack_i), .level_o(level_o), .frame_err_o(frame_err_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: queued transactions, words of the frame in progress, pending block-start
  logic [127:0] mq[$];
  logic [31:0]  wbuf[$];
  bit           fbs;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive, advance model, check all outputs after the edge
  task automatic step(input bit v, input logic [31:0] w, input bit l, input bit b, input bit a);
    bit acc, pop, err, pushed;
    logic [127:0] t;
    word_i = w; word_valid_i = v; word_last_i = l; block_start_i = b; ack_i = a;
    acc = v && (mq.size() < D);
    pop = a && (mq.size() > 0);
    err = 0; pushed = 0;
    if (pop) void'(mq.pop_front());
    if (acc) begin
      wbuf.push_back(w);
      if (l) begin
        if (wbuf.size() == 4) begin
          t = {wbuf[0], wbuf[1], wbuf[2], wbuf[3]};
          t[9] = t[9] | fbs;
          mq.push_back(t);
          fbs = b;
          pushed = 1;
        end else err = 1;
        wbuf.delete();
      end else if (wbuf.size() == 4) begin
        err = 1;
        wbuf.delete();
      end
    end
    if (b && !pushed) fbs = 1;
    @(posedge clk); #1;
    chk("valid", 128'(valid_o), 128'(mq.size() > 0));
    if (mq.size() > 0) chk("data", data_o, mq[0]);
    chk("level", 128'(level_o), 128'(mq.size()));
    chk("ready", 128'(word_ready_o), 128'(mq.size() < D));
    chk("frame_err", 128'(frame_err_o), 128'(err));
  endtask

  task automatic send(input logic [127:0] t);
    for (int i = 0; i < 4; i++) step(1, t[127-32*i -: 32], i == 3, 0, 0);
  endtask

  task automatic do_reset();
    word_valid_i = 0; word_last_i = 0; block_start_i = 0; ack_i = 0;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 128'(valid_o), 128'(0));
    chk("rst_level", 128'(level_o), 128'(0));
    chk("rst_ready", 128'(word_ready_o), 128'(0));
    chk("rst_data", data_o, 128'(0));
    chk("rst_ferr", 128'(frame_err_o), 128'(0));
    mq.delete(); wbuf.delete(); fbs = 1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  initial begin
    logic [127:0] t;
    #2;
    do_reset();

    // 1: first transaction after reset gets bit9 forced
    step(1, 32'hAAAA0000, 0, 0, 0);
    step(1, 32'h0000BBBB, 0, 0, 0);
    step(1, 32'hCCCC0000, 0, 0, 0);
    chk("t1_novalid", 128'(valid_o), 128'(0));
    step(1, 32'h00000C00, 1, 0, 0);
    chk("t1_bs", 128'(data_o[9]), 128'(1));
    chk("t1_amount", 128'(data_o[31:10]), 128'(3));
    chk("t1_level", 128'(level_o), 128'(1));

    // 2: no forcing, then block_start applies only to the next transaction
    step(0, 0, 0, 0, 1);
    send(128'h11112222_33334444_55556666_00000400);
    chk("t2_bs", 128'(data_o[9]), 128'(0));
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0);
    send(128'h0123_4567_89AB_CDEF_0011_2233_0000_1000);
    chk("t3_bs", 128'(data_o[9]), 128'(1));
    step(0, 0, 0, 0, 1);
    send(128'hFEDC_BA98_7654_3210_0000_0000_0000_2000);
    chk("t4_bs", 128'(data_o[9]), 128'(0));
    step(0, 0, 0, 0, 1);

    // 3: early last -> framing error, then a clean frame
    step(1, 32'hDEAD0001, 0, 0, 0);
    step(1, 32'hDEAD0002, 1, 0, 0);
    chk("t5_ferr", 128'(frame_err_o), 128'(1));
    chk("t5_level", 128'(level_o), 128'(0));
    send({$urandom, $urandom, $urandom, $urandom});
    chk("t5_clean", 128'(level_o), 128'(1));
    step(0, 0, 0, 0, 1);

    // 4: fill, stall, one ack reopens
    for (int i = 0; i < D; i++) send({$urandom, $urandom, $urandom, $urandom});
    chk("t6_full_ready", 128'(word_ready_o), 128'(0));
    chk("t6_full_level", 128'(level_o), 128'(D));
    repeat (3) step(1, 32'h5A5A5A5A, 0, 0, 0);
    step(1, 32'h5A5A5A5A, 0, 0, 1);
    chk("t6_reopen_ready", 128'(word_ready_o), 128'(1));
    chk("t6_reopen_level", 128'(level_o), 128'(D-1));
    step(1, 32'h5A5A5A5A, 0, 0, 0);
    step(1, 32'h00000001, 0, 0, 0);
    step(1, 32'h00000002, 0, 0, 0);
    step(1, 32'h00000003, 1, 0, 0);
    while (mq.size() > 1) step(0, 0, 0, 0, 1);

    // 5: push and pop together at level 1, then ack with nothing queued
    t = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 3; i++) step(1, t[127-32*i -: 32], 0, 0, 0);
    step(1, t[31:0], 1, 0, 1);
    chk("t7_level", 128'(level_o), 128'(1));
    chk("t7_valid", 128'(valid_o), 128'(1));
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("t7_empty_ack", 128'(level_o), 128'(0));

    // 6: reset mid-frame with three queued
    for (int i = 0; i < 3; i++) send({$urandom, $urandom, $urandom, $urandom});
    step(1, 32'h12345678, 0, 0, 0);
    step(1, 32'h9ABCDEF0, 0, 0, 0);
    do_reset();
    send(128'h0);
    chk("t8_bs", 128'(data_o[9]), 128'(1));
    step(0, 0, 0, 0, 1);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      bit v, l, b, a;
      v = ($urandom_range(0, 3) != 0);
      l = (wbuf.size() == 3) ^ ($urandom_range(0, 19) == 0);
      b = ($urandom_range(0, 9) == 0);
      a = ($urandom_range(0, 9) < 3);
      step(v, $urandom, l, b, a);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
